// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - doorlock password sequencer
// Collects 4 BCD digits, checks/changes the password, handles timeout and lockout.
module doorlock_ctrl #(
  parameter logic [25:0] T_1S     = 26'h2FA_F080,
  parameter int          OPEN_SEC = 3,
  parameter int          LOCK_SEC = 10,
  parameter int          TO_SEC   = 5,
  parameter int          MAX_FAIL = 3,
  parameter logic [15:0] INIT_PW  = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_i,
  input  logic       star_i,
  output logic       led_o,
  output logic [6:0] fnd_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PGM,
    S_LOCK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pw_q, pw_d;
  logic [3:0]  fail_q, fail_d;
  logic [25:0] pre_q, pre_d;
  logic [3:0]  sec_q, sec_d;

  logic       key_valid;
  logic [3:0] key_dig;
  logic       tick;
  logic       restart;
  logic       to_hit, open_hit, lock_hit;

  always_comb begin
    key_dig = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_i[i]) key_dig = 4'(i);
    end
  end

  // Star always wins over a coincident digit.
  assign key_valid = $onehot(key_i) && !star_i;

  assign tick     = (pre_q == T_1S - 26'd1);
  assign to_hit   = tick && (sec_q == 4'(TO_SEC - 1));
  assign open_hit = tick && (sec_q == 4'(OPEN_SEC - 1));
  assign lock_hit = tick && (sec_q == 4'(LOCK_SEC - 1));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    fail_d  = fail_q;
    restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          state_d = S_ENTRY;
          buf_d   = {12'h000, key_dig};
          cnt_d   = 3'd1;
        end
      end
      S_ENTRY: begin
        if (star_i) begin
          if (cnt_q == 3'd4 && buf_q == pw_q) begin
            state_d = S_OPEN;
            fail_d  = 4'd0;
          end else begin
            fail_d  = fail_q + 4'd1;
            state_d = (fail_q + 4'd1 == 4'(MAX_FAIL)) ? S_LOCK : S_IDLE;
          end
        end else if (key_valid) begin
          restart = 1'b1;
          if (cnt_q != 3'd4) begin
            buf_d = {buf_q[11:0], key_dig};
            cnt_d = cnt_q + 3'd1;
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (star_i) state_d = S_PGM;
        else if (open_hit) state_d = S_IDLE;
      end
      S_PGM: begin
        if (star_i) begin
          if (cnt_q == 3'd4) pw_d = buf_q;
          state_d = S_IDLE;
        end else if (key_valid) begin
          restart = 1'b1;
          if (cnt_q != 3'd4) begin
            buf_d = {buf_q[11:0], key_dig};
            cnt_d = cnt_q + 3'd1;
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (lock_hit) begin
          state_d = S_IDLE;
          fail_d  = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      restart = 1'b1;
      if (state_d == S_IDLE || state_d == S_OPEN || state_d == S_PGM) begin
        buf_d = 16'h0000;
        cnt_d = 3'd0;
      end
    end

    // Timeouts are measured from the last state change or accepted digit.
    if (restart) begin
      pre_d = 26'd0;
      sec_d = 4'd0;
    end else if (tick) begin
      pre_d = 26'd0;
      sec_d = sec_q + 4'd1;
    end else begin
      pre_d = pre_q + 26'd1;
      sec_d = sec_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      pw_q    <= INIT_PW;
      fail_q  <= 4'd0;
      pre_q   <= 26'd0;
      sec_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      fail_q  <= fail_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
    end
  end

  assign led_o = (state_q == S_OPEN);

  always_comb begin
    fnd_o = 7'h7F;
    case (state_q)
      S_ENTRY, S_PGM: begin
        case (cnt_q)
          3'd0:    fnd_o = 7'h40;
          3'd1:    fnd_o = 7'h79;
          3'd2:    fnd_o = 7'h24;
          3'd3:    fnd_o = 7'h30;
          default: fnd_o = 7'h19;
        endcase
      end
      S_OPEN:  fnd_o = 7'h23;
      S_LOCK:  fnd_o = 7'h47;
      default: fnd_o = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - bench for doorlock_ctrl
// Cycle-deadline model checked every negedge, plus directed literal checks.
module tb_doorlock_ctrl;

  localparam logic [25:0] T_1S = 26'd10;
  localparam int OPEN_SEC = 3;
  localparam int LOCK_SEC = 10;
  localparam int TO_SEC   = 5;
  localparam int MAX_FAIL = 3;
  localparam logic [15:0] INIT_PW = 16'h1234;
  localparam int TS = 10;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_PGM = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_i = '0;
  logic       star_i = 1'b0;
  logic       led_o;
  logic [6:0] fnd_o;

  int n_vec = 0;
  int n_err = 0;

  doorlock_ctrl #(
    .T_1S(T_1S), .OPEN_SEC(OPEN_SEC), .LOCK_SEC(LOCK_SEC),
    .TO_SEC(TO_SEC), .MAX_FAIL(MAX_FAIL), .INIT_PW(INIT_PW)
  ) dut (
    .clk(clk), .rst(rst), .key_i(key_i), .star_i(star_i),
    .led_o(led_o), .fnd_o(fnd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode, entered digits, password as a number, and an absolute cycle deadline.
  int         m_mode = M_IDLE;
  int         ent[$];
  int         m_pw = 16'h1234;
  int         m_fail = 0;
  int         deadline = -1;
  int         cyc = 0;
  logic       exp_led = 1'b0;
  logic [6:0] exp_fnd = 7'h7F;

  function automatic int code_of();
    int v = 0;
    foreach (ent[i]) v = v * 16 + ent[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  kd;
    bit  kv;
    if (rst) begin
      m_mode = M_IDLE; ent.delete(); m_pw = INIT_PW; m_fail = 0; deadline = -1;
    end else begin
      cyc++;
      kd = 0;
      for (int i = 0; i < 10; i++) if (key_i[i]) kd = i;
      kv = ($countones(key_i) == 1) && !star_i;
      case (m_mode)
        M_IDLE: if (kv) begin
          m_mode = M_ENTRY; ent = '{kd}; deadline = cyc + TO_SEC * TS;
        end
        M_ENTRY, M_PGM: begin
          if (star_i) begin
            if (m_mode == M_PGM) begin
              if (ent.size() == 4) m_pw = code_of();
              m_mode = M_IDLE;
            end else if (ent.size() == 4 && code_of() == m_pw) begin
              m_mode = M_OPEN; m_fail = 0; deadline = cyc + OPEN_SEC * TS;
            end else begin
              m_fail++;
              if (m_fail == MAX_FAIL) begin
                m_mode = M_LOCK; deadline = cyc + LOCK_SEC * TS;
              end else m_mode = M_IDLE;
            end
            ent.delete();
          end else if (kv) begin
            if (ent.size() < 4) ent.push_back(kd);
            deadline = cyc + TO_SEC * TS;
          end else if (cyc == deadline) begin
            m_mode = M_IDLE; ent.delete();
          end
        end
        M_OPEN: begin
          if (star_i) begin
            m_mode = M_PGM; ent.delete(); deadline = cyc + TO_SEC * TS;
          end else if (cyc == deadline) m_mode = M_IDLE;
        end
        M_LOCK: if (cyc == deadline) begin
          m_mode = M_IDLE; m_fail = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    exp_led = (m_mode == M_OPEN);
    case (m_mode)
      M_ENTRY, M_PGM: begin
        case (ent.size())
          0: exp_fnd = 7'h40;
          1: exp_fnd = 7'h79;
          2: exp_fnd = 7'h24;
          3: exp_fnd = 7'h30;
          default: exp_fnd = 7'h19;
        endcase
      end
      M_OPEN: exp_fnd = 7'h23;
      M_LOCK: exp_fnd = 7'h47;
      default: exp_fnd = 7'h7F;
    endcase
  end

  always @(negedge clk) begin
    check("model_led", {15'd0, led_o}, {15'd0, exp_led});
    check("model_fnd", {9'd0, fnd_o}, {9'd0, exp_fnd});
  end

  task automatic step();
    @(posedge clk);
    #1;
    key_i = '0;
    star_i = 1'b0;
  endtask

  task automatic press(input int d);
    key_i = '0;
    key_i[d] = 1'b1;
    step();
  endtask

  task automatic press_star();
    star_i = 1'b1;
    step();
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic wait_while_fnd(input logic [6:0] v, input int maxc, output int n);
    n = 0;
    while (fnd_o == v && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_led", {15'd0, led_o}, 16'd0);
    check("rst_fnd", {9'd0, fnd_o}, 16'h7F);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int t0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_led", {15'd0, led_o}, 16'd0);
    check("reset_fnd", {9'd0, fnd_o}, 16'h7F);

    // Correct code: open for exactly 30 cycles.
    code4(1, 2, 3, 4);
    press_star();
    check("open_led", {15'd0, led_o}, 16'd1);
    check("open_fnd", {9'd0, fnd_o}, 16'h23);
    n = 1;
    while (led_o && n < 50) begin
      step();
      if (led_o) n++;
    end
    check("open_len", 16'(n), 16'd30);
    check("open_exit_fnd", {9'd0, fnd_o}, 16'h7F);

    // Three failures lock for 100 cycles; code ignored meanwhile.
    repeat (3) begin
      code4(5, 5, 5, 5);
      press_star();
    end
    t0 = cyc;
    check("lock_fnd", {9'd0, fnd_o}, 16'h47);
    code4(1, 2, 3, 4);
    press_star();
    check("lock_ignore_led", {15'd0, led_o}, 16'd0);
    check("lock_ignore_fnd", {9'd0, fnd_o}, 16'h47);
    wait_while_fnd(7'h47, 200, n);
    check("lock_len", 16'(cyc - t0), 16'd100);
    code4(1, 2, 3, 4);
    press_star();
    check("post_lock_open", {15'd0, led_o}, 16'd1);
    press_star();
    check("pgm_fnd", {9'd0, fnd_o}, 16'h40);
    press_star();
    check("pgm_abort_fnd", {9'd0, fnd_o}, 16'h7F);

    // Password change to 9876.
    code4(1, 2, 3, 4); press_star(); press_star();
    code4(9, 8, 7, 6); press_star();
    check("pgm_done_fnd", {9'd0, fnd_o}, 16'h7F);
    code4(1, 2, 3, 4); press_star();
    check("old_pw_led", {15'd0, led_o}, 16'd0);
    code4(9, 8, 7, 6); press_star();
    check("new_pw_led", {15'd0, led_o}, 16'd1);
    press_star(); press(1); press(2);
    check("pgm_cnt2_fnd", {9'd0, fnd_o}, 16'h24);
    press_star();
    code4(9, 8, 7, 6); press_star();
    check("pw_kept_led", {15'd0, led_o}, 16'd1);
    press_star(); press_star();

    // Boundaries.
    do_reset();
    key_i = 10'h003;
    step();
    check("multi_key_fnd", {9'd0, fnd_o}, 16'h7F);
    code4(1, 2, 3, 4); press(5);
    check("fifth_fnd", {9'd0, fnd_o}, 16'h19);
    press_star();
    check("fifth_open", {15'd0, led_o}, 16'd1);
    press_star(); press_star();
    press(1); press(2); press(3); press_star();
    check("short_led", {15'd0, led_o}, 16'd0);
    check("short_fnd", {9'd0, fnd_o}, 16'h7F);

    // Timeout leaves fail at 1: one more failure must not lock.
    press(1); press(2);
    t0 = cyc;
    wait_while_fnd(7'h24, 100, n);
    check("timeout_len", 16'(cyc - t0), 16'd50);
    code4(5, 5, 5, 5); press_star();
    check("timeout_fail_kept", {9'd0, fnd_o}, 16'h7F);
    press(3);
    repeat (48) step();
    press(4);
    check("restart_fnd", {9'd0, fnd_o}, 16'h24);
    t0 = cyc;
    wait_while_fnd(7'h24, 100, n);
    check("restart_len", 16'(cyc - t0), 16'd50);
    code4(1, 2, 3, 4); press_star();
    check("clear_fail_open", {15'd0, led_o}, 16'd1);

    // Reset mid-OPEN and after a password change.
    repeat (5) step();
    do_reset();
    code4(1, 2, 3, 4); press_star(); press_star();
    code4(5, 6, 7, 8); press_star();
    do_reset();
    code4(5, 6, 7, 8); press_star();
    check("rst_pw_new_led", {15'd0, led_o}, 16'd0);
    code4(1, 2, 3, 4); press_star();
    check("rst_pw_init_led", {15'd0, led_o}, 16'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/doorlock_ctrl.md
# doorlock_ctrl

Password sequencer for the DE0 doorlock. Consumes the debounced, single-cycle key pulses from the button interface (10 digit keys plus star), collects a 4-digit BCD code, compares it with a stored password, and drives the door LED and a 7-segment status digit. It also handles password change, entry timeout and lockout after repeated failures, using an internal 1 s tick.

## Interface
- T_1S, 26'h2FA_F080 (50,000,000): clk cycles per second tick.
- OPEN_SEC, 3: seconds the door stays open.
- LOCK_SEC, 10: lockout duration in seconds.
- TO_SEC, 5: idle timeout in seconds during ENTRY/PGM.
- MAX_FAIL, 3: consecutive failures that trigger lockout (legal 1..15).
- INIT_PW, 16'h1234: reset password, BCD, first digit in [15:12].
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_i  input  10  one-cycle digit pulses; bit k = digit k.
- star_i  input  1  one-cycle star/enter pulse.
- led_o  output  1  door open indicator.
- fnd_o  output  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Key decode: a key event is valid only if exactly one key_i bit is high; zero or multiple bits mean no key. If star_i and a valid key coincide, the key is dropped and star is processed.
- Entry buffer: 16-bit code register `buf`, digit counter `cnt` (0..4). Accepted digit: buf <= {buf[11:0], k}, cnt <= cnt+1. When cnt==4, further digits are ignored (buf unchanged).
- Registers: password `pw` (16 bit), fail counter `fail` (4 bit), prescaler, second counter.
- States:
  - IDLE: cnt=0. A digit loads the buffer, sets cnt=1, and moves to ENTRY. Star is ignored.
  - ENTRY: digits are accepted per the buffer rules. On star: if cnt==4 and buf==pw, go to OPEN and clear fail. Otherwise increment fail; if fail+1==MAX_FAIL go to LOCK, else go to IDLE. A timeout goes to IDLE with fail unchanged.
  - OPEN: digits are ignored. Star goes to PGM with cnt=0. After OPEN_SEC seconds, go to IDLE.
  - PGM: digits are accepted per the buffer rules. Star with cnt==4 sets pw <= buf and goes to IDLE. Star with cnt<4 goes to IDLE with pw unchanged. A timeout goes to IDLE with pw unchanged.
  - LOCK: all inputs are ignored. After LOCK_SEC seconds, go to IDLE and clear fail.
- cnt and buf clear on every transition into IDLE, OPEN or PGM.
- Seconds timer: the prescaler counts 0..T_1S-1 and pulses a tick at T_1S-1. The prescaler and second counter restart on every state change and on every accepted digit in ENTRY/PGM, so the timeout is measured from the last activity.
- Outputs are a combinational decode of the registered state/cnt:
  - led_o = 1 only in OPEN.
  - fnd_o in IDLE: blank, 7'h7F.
  - fnd_o in ENTRY/PGM: digit cnt (0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19).
  - fnd_o in OPEN: 'o', 7'h23.
  - fnd_o in LOCK: 'L', 7'h47.
- Reset values: state IDLE, pw=INIT_PW, fail=0, cnt=0, buf=0, timers 0, led_o=0, fnd_o=7'h7F.

## Timing
- Input pulse sampled at edge N: state, cnt and outputs update at edge N, with no further latency.
- OPEN, LOCK and timeout durations are exactly N_SEC×T_1S cycles from the entry/activity edge to the exit edge.
- A timeout tick and a key in the same cycle: the key wins and the timer restarts.
- A timer expiry and star in the same cycle in OPEN: star wins, and the state goes to PGM.
- rst asserted in any state (including mid-OPEN or mid-LOCK): immediate return to reset values, and pw reverts to INIT_PW.
- Back-to-back key pulses on consecutive cycles are all accepted.

## Test plan
- Correct code: T_1S=10, keys 1,2,3,4, then star → led_o=1 and fnd_o=7'h23 for exactly 30 cycles, then IDLE and fnd_o=7'h7F.
- Three wrong codes (5,5,5,5 + star), MAX_FAIL=3 → the third star enters LOCK with fnd_o=7'h47. The correct code during LOCK is ignored. After 100 cycles the state is IDLE and the correct code then opens the door.
- Password change: open, star, then 9,8,7,6 + star → IDLE. Code 1234 now fails; 9876 opens. A PGM star with cnt=2 leaves pw unchanged.
- Boundaries: key_i=10'h003 is ignored; a 5th digit is ignored and the code still matches; a short code (1,2,3 + star) counts as a failure.
- Timeout: 2 digits, then no input for 50 cycles → IDLE with fnd_o=7'h7F and fail unchanged. A digit at cycle 49 restarts the timer.
- Reset mid-OPEN and after a password change → led_o=0, fnd_o=7'h7F, and pw=16'h1234 is restored.
